// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command responder.
//   - state_t      : command/response FSM states
//   - OP_*         : command opcodes
//   - ST_*         : response status codes
//   - resp_buf_t   : response buffer (status, up to 4 data bytes, checksum)
//   - xor_bytes32  : XOR of the four bytes of a 32-bit word
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_OPC     = 3'd1,
        S_ADDR    = 3'd2,
        S_DATA    = 3'd3,
        S_CSUM    = 3'd4,
        S_EXEC    = 3'd5,
        S_RD_WAIT = 3'd6,
        S_RESP    = 3'd7
    } state_t;

    localparam logic [7:0] OP_WR    = 8'h01;
    localparam logic [7:0] OP_RD    = 8'h02;

    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_BADCS = 8'hE1;
    localparam logic [7:0] ST_BADOP = 8'hE2;
    localparam logic [7:0] ST_TMO   = 8'hE3;

    localparam int unsigned RESP_BUF_BYTES = 6;
    typedef logic [RESP_BUF_BYTES-1:0][7:0] resp_buf_t;

    function automatic logic [7:0] xor_bytes32(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Register bus between the UART command responder and the register file.
//   master (responder): drives reg_addr, reg_wdata, reg_we, reg_re;
//                       receives reg_rdata, reg_rvalid.
//   slave  (reg file) : the opposite directions.
interface uart_cmd_responder_if;

    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;

    modport master (
        output reg_addr, reg_wdata, reg_we, reg_re,
        input  reg_rdata, reg_rvalid
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_we, reg_re,
        output reg_rdata, reg_rvalid
    );

endinterface

// File: rtl/uart_cmd_txseq.sv
// Streams a response frame to the UART transmitter: SYNC_TX first, then
// resp_len bytes of resp_buf starting at index 0.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   start             : one-cycle pulse, latches resp_len and begins a frame
//   resp_buf/resp_len : bytes following the sync byte and their count
//   tx_busy           : transmitter busy
//   tx_start/tx_data  : one-cycle launch pulse and held byte
//   done              : one-cycle pulse once the last byte has left the line
module uart_cmd_txseq
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_TX = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  resp_buf_t  resp_buf,
    input  logic [2:0] resp_len,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       done
);

    logic       active_r;
    logic [2:0] idx_r;
    logic [2:0] last_r;
    logic       tx_start_r;
    logic       guard_r;
    logic [7:0] tx_data_r;
    logic       done_r;

    // Launch sequencer. The two cycles after a launch ignore tx_busy so the
    // transmitter's delayed busy rise is never mistaken for idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r   <= 1'b0;
            idx_r      <= 3'd0;
            last_r     <= 3'd0;
            tx_start_r <= 1'b0;
            guard_r    <= 1'b0;
            tx_data_r  <= 8'h00;
            done_r     <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            done_r     <= 1'b0;
            guard_r    <= tx_start_r;
            if (start) begin
                active_r <= 1'b1;
                idx_r    <= 3'd0;
                last_r   <= resp_len;
            end else if (active_r && !tx_start_r && !guard_r && !tx_busy) begin
                if (idx_r > last_r) begin
                    active_r <= 1'b0;
                    done_r   <= 1'b1;
                end else begin
                    tx_start_r <= 1'b1;
                    tx_data_r  <= (idx_r == 3'd0) ? SYNC_TX : resp_buf[idx_r - 3'd1];
                    idx_r      <= idx_r + 3'd1;
                end
            end else begin
                active_r <= active_r;
            end
        end
    end

    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign done     = done_r;

endmodule

// File: rtl/uart_cmd_responder.sv
// Host-facing command endpoint: parses framed read/write commands from the
// UART receiver, drives the register bus, and returns a framed response.
// Optional build macro: UART_CMD_TIMEOUT_EN enables the inter-byte and
// read-completion timeout counter.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   rx_valid, rx_data : received byte strobe and value
//   tx_busy           : transmitter busy
//   tx_start, tx_data : transmitter launch pulse and byte
//   frame_err         : one-cycle pulse on checksum/opcode/timeout error
//   reg_bus           : register bus (master side)
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLKFREQ        = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_RX        = 8'hA5,
    parameter logic [7:0]  SYNC_TX        = 8'h5A
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    input  logic                        tx_busy,
    output logic                        tx_start,
    output logic [7:0]                  tx_data,
    output logic                        frame_err,
    uart_cmd_responder_if.master        reg_bus
);

    // The timeout counter is 20 bits wide.
    if (CLKFREQ == 0 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1048576) begin : g_bad_cfg
        $error("uart_cmd_responder: unsupported CLKFREQ/TIMEOUT_CYCLES");
    end

    state_t     state_r;
    logic [7:0] opc_r;
    logic [7:0] csum_r;
    logic [7:0] addr_sh_r;
    logic [31:0] wdata_sh_r;
    logic [1:0] data_cnt_r;
    logic [7:0] status_r;
    logic [7:0] reg_addr_r;
    logic [31:0] reg_wdata_r;
    logic       reg_we_r;
    logic       reg_re_r;
    logic       frame_err_r;
    logic       resp_go_r;
    resp_buf_t  resp_buf_r;
    logic [2:0] resp_len_r;
    logic       seq_done_s;
    logic       opc_ok_s;
    logic       frame_active_s;

    assign opc_ok_s       = (opc_r == OP_WR) || (opc_r == OP_RD);
    assign frame_active_s = (state_r == S_OPC) || (state_r == S_ADDR) ||
                            (state_r == S_DATA) || (state_r == S_CSUM);

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] tmo_cnt_r;
    logic        tmo_hit_s;
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

    // Cycles since the last accepted frame byte, or since entering the read wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_r <= 20'd0;
        end else if ((frame_active_s && rx_valid) || state_r == S_IDLE || state_r == S_EXEC) begin
            tmo_cnt_r <= 20'd0;
        end else if (!tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + 20'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`endif

    // Command parser, register-bus strobes and response buffer build.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            opc_r       <= 8'h00;
            csum_r      <= 8'h00;
            addr_sh_r   <= 8'h00;
            wdata_sh_r  <= 32'h0;
            data_cnt_r  <= 2'd0;
            status_r    <= ST_OK;
            reg_addr_r  <= 8'h00;
            reg_wdata_r <= 32'h0;
            reg_we_r    <= 1'b0;
            reg_re_r    <= 1'b0;
            frame_err_r <= 1'b0;
            resp_go_r   <= 1'b0;
            resp_buf_r  <= '0;
            resp_len_r  <= 3'd0;
        end else begin
            reg_we_r    <= 1'b0;
            reg_re_r    <= 1'b0;
            frame_err_r <= 1'b0;
            resp_go_r   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (rx_valid && rx_data == SYNC_RX) state_r <= S_OPC;
                    else                                state_r <= S_IDLE;
                end
                S_OPC: begin
                    if (rx_valid) begin
                        opc_r   <= rx_data;
                        csum_r  <= rx_data;
                        state_r <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        addr_sh_r  <= rx_data;
                        csum_r     <= csum_r ^ rx_data;
                        data_cnt_r <= 2'd0;
                        // Unknown opcodes are consumed with read-frame length.
                        state_r    <= (opc_r == OP_WR) ? S_DATA : S_CSUM;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        wdata_sh_r <= {wdata_sh_r[23:0], rx_data};
                        csum_r     <= csum_r ^ rx_data;
                        data_cnt_r <= data_cnt_r + 2'd1;
                        if (data_cnt_r == 2'd3) state_r <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        state_r <= S_EXEC;
                        if (!opc_ok_s) begin
                            status_r    <= ST_BADOP;
                            frame_err_r <= 1'b1;
                        end else if (csum_r != rx_data) begin
                            status_r    <= ST_BADCS;
                            frame_err_r <= 1'b1;
                        end else begin
                            status_r   <= ST_OK;
                            reg_addr_r <= addr_sh_r;
                            if (opc_r == OP_WR) begin
                                reg_wdata_r <= wdata_sh_r;
                                reg_we_r    <= 1'b1;
                            end else begin
                                reg_re_r    <= 1'b1;
                            end
                        end
                    end
                end
                S_EXEC: begin
                    if (status_r == ST_OK && opc_r == OP_RD) begin
                        state_r <= S_RD_WAIT;
                    end else begin
                        // Status-only response: checksum equals the status byte.
                        resp_buf_r[0] <= status_r;
                        resp_buf_r[1] <= status_r;
                        resp_len_r    <= 3'd2;
                        resp_go_r     <= 1'b1;
                        state_r       <= S_RESP;
                    end
                end
                S_RD_WAIT: begin
                    if (reg_bus.reg_rvalid) begin
                        resp_buf_r <= {ST_OK ^ xor_bytes32(reg_bus.reg_rdata),
                                       reg_bus.reg_rdata[7:0],   reg_bus.reg_rdata[15:8],
                                       reg_bus.reg_rdata[23:16], reg_bus.reg_rdata[31:24],
                                       ST_OK};
                        resp_len_r <= 3'd6;
                        resp_go_r  <= 1'b1;
                        state_r    <= S_RESP;
                    end
`ifdef UART_CMD_TIMEOUT_EN
                    else if (tmo_hit_s) begin
                        resp_buf_r[0] <= ST_TMO;
                        resp_buf_r[1] <= ST_TMO;
                        resp_len_r    <= 3'd2;
                        resp_go_r     <= 1'b1;
                        frame_err_r   <= 1'b1;
                        state_r       <= S_RESP;
                    end
`endif
                end
                S_RESP: begin
                    // Received bytes are dropped until the frame is fully sent.
                    if (seq_done_s) state_r <= S_IDLE;
                    else            state_r <= S_RESP;
                end
                default: state_r <= S_IDLE;
            endcase
`ifdef UART_CMD_TIMEOUT_EN
            // A stalled command frame is abandoned silently.
            if (frame_active_s && !rx_valid && tmo_hit_s) begin
                frame_err_r <= 1'b1;
                state_r     <= S_IDLE;
            end
`endif
        end
    end

    uart_cmd_txseq #(.SYNC_TX(SYNC_TX)) u_txseq (
        .clk      (clk),
        .rst      (rst),
        .start    (resp_go_r),
        .resp_buf (resp_buf_r),
        .resp_len (resp_len_r),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .done     (seq_done_s)
    );

    assign reg_bus.reg_addr  = reg_addr_r;
    assign reg_bus.reg_wdata = reg_wdata_r;
    assign reg_bus.reg_we    = reg_we_r;
    assign reg_bus.reg_re    = reg_re_r;
    assign frame_err         = frame_err_r;

endmodule
